// File: rtl/ppg_afe_pkg.sv
// ppg_afe_pkg: shared source encoding and arithmetic constants for the PPG AFE model
package ppg_afe_pkg;
  // Encoding matches {LED_IR, LED_RED} so the decode is a plain cast
  typedef enum logic [1:0] {SRC_NONE, SRC_RED, SRC_IR, SRC_BOTH} src_t;
  localparam int ADC_MID = 128;
  localparam int ADC_MAX = 255;
  localparam int CALC_W  = 20;
endpackage

// File: rtl/ppg_afe_model_wave.sv
// ppg_wave_gen: heartbeat phase counter, triangle shaping and pulsatile amplitude scaling
//   CLK, rst_n : clock, async active-low reset
//   amp        : pulsatile amplitude of the selected LED (8b)
//   ac         : scaled pulsatile term, 0..amp (8b)
module ppg_wave_gen #(
  parameter int PHASE_W = 7
) (
  input  logic       CLK,
  input  logic       rst_n,
  input  logic [7:0] amp,
  output logic [7:0] ac
);
  logic [PHASE_W-1:0] phase;
  logic [PHASE_W-2:0] tri_v;
  logic [PHASE_W+6:0] prod;
  always_ff @(posedge CLK or negedge rst_n)
    if (!rst_n) phase <= '0;
    else phase <= phase + 1'b1;
  // Falling half mirrors the rising half, giving 0..2**(PHASE_W-1)-1 and back
  assign tri_v = phase[PHASE_W-1] ? ~phase[PHASE_W-2:0] : phase[PHASE_W-2:0];
  assign prod  = {{(PHASE_W-1){1'b0}}, amp} * {8'd0, tri_v};
  assign ac    = 8'(prod >> (PHASE_W-1));
endmodule

// File: rtl/ppg_afe_model.sv
// ppg_afe_model: photodiode + DC-comp DAC + PGA + 8-bit ADC model for closed-loop simulation
//   CLK, rst_n   : clock, async active-low reset
//   LED_DRIVE    : LED current code (4b)
//   LED_RED/IR   : LED enables; both or none select no LED
//   DC_Comp      : DC-compensation code (7b)
//   PGA_Gain     : gain code, gain = PGA_Gain+1 (4b)
//   ADC          : sampled ADC code (8b)
//   adc_sat      : current sample clipped at 0 or 255
//   led_conflict : both LED enables were high
module ppg_afe_model
  import ppg_afe_pkg::*;
#(
  parameter int PHASE_W    = 7,
  parameter int RED_DC     = 20,
  parameter int RED_AC     = 0,
  parameter int IR_DC      = 24,
  parameter int IR_AC      = 0,
  parameter int AMBIENT    = 0,
  parameter int DC_STEP    = 4,
  parameter int OUT_SHIFT  = 2,
  parameter int SETTLE_CYC = 3
) (
  input  logic       CLK,
  input  logic       rst_n,
  input  logic [3:0] LED_DRIVE,
  input  logic       LED_RED,
  input  logic       LED_IR,
  input  logic [6:0] DC_Comp,
  input  logic [3:0] PGA_Gain,
  output logic [7:0] ADC,
  output logic       adc_sat,
  output logic       led_conflict
);
  src_t src, src_q;
  logic [7:0] ac_amp, ac, dc_sel, adc_d, settle_cnt;
  logic [CALC_W-1:0] photo, sub;
  logic signed [CALC_W-1:0] comp_d, comp_q, gain_s, prod, v;
  logic sat_d, sat_hi;
  assign src    = src_t'({LED_IR, LED_RED});
  assign ac_amp = src == SRC_IR ? 8'(IR_AC) : 8'(RED_AC);
  assign dc_sel = src == SRC_IR ? 8'(IR_DC) : 8'(RED_DC);
  ppg_wave_gen #(.PHASE_W(PHASE_W)) u_wave (
    .CLK   (CLK),
    .rst_n (rst_n),
    .amp   (ac_amp),
    .ac    (ac)
  );
  // Products stay unsigned at full width; only the compensated difference is signed
  always_comb begin
    photo  = (src == SRC_RED || src == SRC_IR) ?
             CALC_W'(LED_DRIVE) * (CALC_W'(dc_sel) + CALC_W'(ac)) + CALC_W'(AMBIENT) :
             CALC_W'(AMBIENT);
    sub    = CALC_W'(DC_Comp) * CALC_W'(DC_STEP);
    comp_d = signed'(photo - sub);
    gain_s = signed'(CALC_W'(PGA_Gain) + CALC_W'(1));
    prod   = comp_q * gain_s;
    v      = signed'(CALC_W'(ADC_MID)) + (prod >>> OUT_SHIFT);
    sat_hi = !v[CALC_W-1] && v > signed'(CALC_W'(ADC_MAX));
    sat_d  = sat_hi || v[CALC_W-1];
    adc_d  = sat_hi ? 8'(ADC_MAX) : v[CALC_W-1] ? 8'd0 : v[7:0];
  end
  // Settling compares the incoming source with the registered one, so the
  // ADC holds its old value for SETTLE_CYC edges after the new sample enters stage 2
  always_ff @(posedge CLK or negedge rst_n)
    if (!rst_n) begin
      comp_q       <= '0;
      src_q        <= SRC_NONE;
      led_conflict <= 1'b0;
      settle_cnt   <= '0;
      ADC          <= '0;
      adc_sat      <= 1'b0;
    end else begin
      comp_q       <= comp_d;
      src_q        <= src;
      led_conflict <= src == SRC_BOTH;
      settle_cnt   <= src != src_q ? 8'(SETTLE_CYC) : settle_cnt != '0 ? settle_cnt - 8'd1 : settle_cnt;
      if (settle_cnt == '0) begin
        ADC     <= adc_d;
        adc_sat <= sat_d;
      end
    end
endmodule
